// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store bus initiator with alignment, range and timeout exceptions
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT     = 32'h0000_2FFF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [4:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  op_width;
    logic        op_sign;
    logic [1:0]  op_lane;

    logic        illegal;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [15:0] lane_h;
    logic [7:0]  lane_b;
    logic [31:0] ext_data;

    always_comb begin
        illegal = 1'b0;
        be_next = 4'b0000;
        wd_next = req_wdata;
        case (req_width)
            2'd0: begin
                illegal = (req_addr[1:0] != 2'b00);
                be_next = 4'b1111;
            end
            2'd1: begin
                illegal = req_addr[0];
                be_next = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                be_next = 4'b0001 << req_addr[1:0];
                wd_next = {4{req_wdata[7:0]}};
            end
            default: illegal = 1'b1;
        endcase
        if (req_addr > ADDR_LIMIT)
            illegal = 1'b1;
    end

    // Lane selection uses the address captured at acceptance, not the live request.
    always_comb begin
        lane_h   = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        lane_b   = bus_rdata[{op_lane, 3'b000} +: 8];
        ext_data = bus_rdata;
        case (op_width)
            2'd1:    ext_data = {{16{op_sign & lane_h[15]}}, lane_h};
            2'd2:    ext_data = {{24{op_sign & lane_b[7]}}, lane_b};
            default: ext_data = bus_rdata;
        endcase
    end

    assign req_stall = req_valid & ~done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            op_width   <= 2'd0;
            op_sign    <= 1'b0;
            op_lane    <= 2'd0;
            done       <= 1'b0;
            rdata      <= 32'd0;
            exc_code   <= 5'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_byteen <= 4'd0;
            bus_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            exc_code <= req_we ? EXC_ADES : EXC_ADEL;
                            done     <= 1'b1;
                            state    <= RESP;
                        end else begin
                            op_width   <= req_width;
                            op_sign    <= req_sign;
                            op_lane    <= req_addr[1:0];
                            bus_we     <= req_we;
                            bus_addr   <= {req_addr[31:2], 2'b00};
                            bus_byteen <= be_next;
                            bus_wdata  <= wd_next;
                            bus_req    <= 1'b1;
                            cnt        <= 8'd0;
                            state      <= BUS;
                        end
                    end
                end
                BUS: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        if (!bus_we)
                            rdata <= ext_data;
                        exc_code <= 5'd0;
                        done     <= 1'b1;
                        state    <= RESP;
                    end else if (cnt == TO_LAST) begin
                        bus_req  <= 1'b0;
                        exc_code <= EXC_DBE;
                        done     <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    done     <= 1'b0;
                    exc_code <= 5'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven bench for mem_access_unit with a wait-state slave model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        req_stall, done;
    logic [31:0] rdata;
    logic [4:0]  exc_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_width(req_width), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_stall(req_stall), .done(done), .rdata(rdata), .exc_code(exc_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          wt;
        logic [4:0]  exc;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
    } vec_t;

    vec_t vec [16];
    int total = 0;
    int bad = 0;
    logic [31:0] model_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int cyc, nbus, exp_cyc, exp_nbus;
        logic seen;
        logic legal;
        legal    = (v.exc == 5'd0) || (v.exc == 5'd7);
        exp_nbus = legal ? ((v.wt + 1 < 255) ? v.wt + 1 : 255) : 0;
        exp_cyc  = legal ? exp_nbus + 1 : 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_width = v.width; req_sign = v.sign;
        req_addr = v.addr; req_wdata = v.wdata; bus_ack = 1'b0; bus_rdata = 32'h0;
        cyc = 0; nbus = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            // Scramble the live request to show it is ignored after acceptance.
            req_addr = 32'hFFFF_FFFF; req_width = 2'd3; req_wdata = 32'h0;
            if (done) begin
                seen = 1'b1;
                chk($sformatf("v%0d exc", idx), 32'(exc_code), 32'(v.exc));
                chk($sformatf("v%0d latency", idx), cyc, exp_cyc);
                chk($sformatf("v%0d buscycles", idx), nbus, exp_nbus);
                if (legal && !v.we) model_rdata = v.rd;
                chk($sformatf("v%0d rdata", idx), rdata, model_rdata);
                chk($sformatf("v%0d stall_in_done", idx), 32'(req_stall), 32'd0);
                bus_ack = 1'b0;
                req_valid = 1'b0;
            end else if (bus_req) begin
                nbus++;
                if (nbus == 1) begin
                    chk($sformatf("v%0d bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d byteen", idx), 32'(bus_byteen), 32'(v.be));
                    chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.we));
                    if (v.we) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
                    chk($sformatf("v%0d stall_busy", idx), 32'(req_stall), 32'd1);
                end
                bus_ack   = (nbus > v.wt);
                bus_rdata = bus_ack ? v.brd : 32'hA5A5_A5A5;
            end
        end
        if (!seen) chk($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d exc_cleared", idx), 32'(exc_code), 32'd0);
        chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    endtask

    initial begin
        //            we  w     s     addr          wdata         bus_rdata     wt   exc   be       bwd           rdata
        vec[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0,   5'd0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vec[1]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0013, 32'h0,        32'h80FF_0000, 0,   5'd0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vec[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0013, 32'h0,        32'h80FF_0000, 1,   5'd0, 4'b1000, 32'h0,        32'h0000_0080};
        vec[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h0,        2,   5'd0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vec[4]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        0,   5'd4, 4'b0000, 32'h0,        32'h0};
        vec[5]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        0,   5'd5, 4'b0000, 32'h0,        32'h0};
        vec[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_002E, 32'h0,        32'h8001_7FFF, 1,   5'd0, 4'b1100, 32'h0,        32'hFFFF_8001};
        vec[7]  = '{1'b0, 2'd1, 1'b0, 32'h0000_002C, 32'h0,        32'h1234_F00D, 0,   5'd0, 4'b0011, 32'h0,        32'h0000_F00D};
        vec[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'h0,        32'h0,        0,   5'd4, 4'b0000, 32'h0,        32'h0};
        vec[9]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0,   5'd5, 4'b0000, 32'h0,        32'h0};
        vec[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_2FFF, 32'h0000_0055, 32'h0,        3,   5'd0, 4'b1000, 32'h5555_5555, 32'h0};
        vec[11] = '{1'b0, 2'd2, 1'b1, 32'h0000_2FFD, 32'h0,        32'h0000_7F00, 0,   5'd0, 4'b0010, 32'h0,        32'h0000_007F};
        vec[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        0,   5'd4, 4'b0000, 32'h0,        32'h0};
        vec[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'h0000_00C3, 32'h0,        255, 5'd7, 4'b0010, 32'hC3C3_C3C3, 32'h0};
        vec[14] = '{1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'h0000_00C3, 32'h0,        254, 5'd0, 4'b0010, 32'hC3C3_C3C3, 32'h0};
        vec[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_2FFC, 32'h0,        32'h0BAD_F00D, 0,   5'd0, 4'b1111, 32'h0,        32'h0BAD_F00D};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst exc", 32'(exc_code), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst byteen", 32'(bus_byteen), 32'd0);
        chk("rst stall", 32'(req_stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_op(i, vec[i]);

        // Stray ack while idle must not start or finish anything.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        chk("idle ack done", 32'(done), 32'd0);
        chk("idle ack bus_req", 32'(bus_req), 32'd0);
        bus_ack = 1'b0;

        // Reset during BUS after three wait states.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'd0; req_addr = 32'h0000_0040;
        repeat (3) @(negedge clk);
        chk("pre-reset bus_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid-reset bus_req", 32'(bus_req), 32'd0);
        chk("mid-reset done", 32'(done), 32'd0);
        chk("mid-reset rdata", rdata, 32'd0);
        reset = 1'b0; req_valid = 1'b0;
        model_rdata = 32'h0;
        run_op(16, vec[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
